// File: rtl/cmd_seq_pkg.sv
// Shared opcodes, status bytes, FSM states and frame geometry for the command sequencer.
package cmd_seq_pkg;

    localparam logic [7:0] OP_SET_ADDR  = 8'h01;
    localparam logic [7:0] OP_SET_WDATA = 8'h02;
    localparam logic [7:0] OP_WRITE     = 8'h03;
    localparam logic [7:0] OP_READ      = 8'h04;
    localparam logic [7:0] OP_GET_ADDR  = 8'h05;

    localparam logic [7:0] ST_ACK     = 8'h00;
    localparam logic [7:0] ST_BADOP   = 8'hEE;
    localparam logic [7:0] ST_TIMEOUT = 8'hE1;

    localparam int FRAME_LEN = 5;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        EXEC     = 2'd1,
        WAIT_MEM = 2'd2,
        RESP     = 2'd3
    } state_t;

    // Single-byte responses ride in the top byte so the serializer always shifts MSB first.
    function automatic logic [31:0] status_word(input logic [7:0] status);
        return {status, 24'h000000};
    endfunction

endpackage

// File: rtl/cmd_sequencer_resp_serializer.sv
// Shifts out 1..4 loaded bytes MSB first; one byte per strobe, strobes never back to back.
// Waits while tx_ready is low; done pulses with the final strobe.
module resp_serializer (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [31:0] load_data,
    input  logic [2:0]  load_count,
    input  logic        tx_ready,
    output logic        tx_strb,
    output logic [7:0]  tx_data,
    output logic        done
);

    logic [31:0] shreg;
    logic [2:0]  left;

    always_ff @(posedge clk) begin
        if (reset) begin
            shreg   <= '0;
            left    <= '0;
            tx_strb <= 1'b0;
            tx_data <= '0;
        end else if (load) begin
            shreg   <= load_data;
            left    <= load_count;
            tx_strb <= 1'b0;
        end else if (tx_strb) begin
            tx_strb <= 1'b0;
        end else if (left != 3'd0 && tx_ready) begin
            tx_strb <= 1'b1;
            tx_data <= shreg[31:24];
            shreg   <= {shreg[23:0], 8'h00};
            left    <= left - 3'd1;
        end
    end

    assign done = tx_strb && (left == 3'd0);

endmodule

// File: rtl/cmd_sequencer.sv
// Assembles 5-byte command frames, runs one memory transaction or register update, answers on tx.
// Response starts >=3 cycles after the last byte; bytes received while busy are dropped with err_strb.
module cmd_sequencer
    import cmd_seq_pkg::*;
#(
    parameter int FRAME_TO = 65535,
    parameter int MEM_TO   = 1023
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_strb,
    input  logic [7:0]  rx_data,
    input  logic        tx_ready,
    output logic        tx_strb,
    output logic [7:0]  tx_data,
    output logic        mem_start,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_done,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        err_strb
);

    state_t      state;
    logic [39:0] frame;
    logic [2:0]  byte_cnt;
    logic [15:0] frame_tmr;
    logic [9:0]  mem_tmr;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic [31:0] resp_word;
    logic        ser_load;
    logic [2:0]  ser_count;
    logic        ser_done;
    logic [7:0]  opcode;
    logic [31:0] operand;

    assign opcode    = frame[39:32];
    assign operand   = frame[31:0];
    assign mem_addr  = addr_reg;
    assign mem_wdata = wdata_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            frame     <= '0;
            byte_cnt  <= '0;
            frame_tmr <= '0;
            mem_tmr   <= '0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            resp_word <= '0;
            ser_load  <= 1'b0;
            ser_count <= '0;
            mem_start <= 1'b0;
            mem_we    <= 1'b0;
            busy      <= 1'b0;
            err_strb  <= 1'b0;
        end else begin
            ser_load  <= 1'b0;
            mem_start <= 1'b0;
            err_strb  <= rx_strb && (state != IDLE);
            case (state)
                IDLE: begin
                    if (rx_strb) begin
                        frame     <= {frame[31:0], rx_data};
                        frame_tmr <= '0;
                        if (byte_cnt == 3'(FRAME_LEN - 1)) begin
                            byte_cnt <= '0;
                            state    <= EXEC;
                            busy     <= 1'b1;
                        end else begin
                            byte_cnt <= byte_cnt + 3'd1;
                        end
                    end else if (byte_cnt == 3'd0) begin
                        frame_tmr <= '0;
                    end else if (frame_tmr == 16'(FRAME_TO - 1)) begin
                        byte_cnt  <= '0;
                        frame_tmr <= '0;
                    end else if (frame_tmr != 16'hFFFF) begin
                        frame_tmr <= frame_tmr + 16'd1;
                    end
                end
                EXEC: begin
                    mem_tmr <= '0;
                    case (opcode)
                        OP_SET_ADDR, OP_SET_WDATA: begin
                            if (opcode == OP_SET_ADDR) addr_reg <= operand;
                            else                       wdata_reg <= operand;
                            resp_word <= status_word(ST_ACK);
                            ser_count <= 3'd1;
                            ser_load  <= 1'b1;
                            state     <= RESP;
                        end
                        OP_WRITE, OP_READ: begin
                            mem_start <= 1'b1;
                            mem_we    <= (opcode == OP_WRITE);
                            state     <= WAIT_MEM;
                        end
                        OP_GET_ADDR: begin
                            resp_word <= addr_reg;
                            ser_count <= 3'd4;
                            ser_load  <= 1'b1;
                            state     <= RESP;
                        end
                        default: begin
                            resp_word <= status_word(ST_BADOP);
                            ser_count <= 3'd1;
                            ser_load  <= 1'b1;
                            err_strb  <= 1'b1;
                            state     <= RESP;
                        end
                    endcase
                end
                WAIT_MEM: begin
                    // resp_word doubles as the read-capture register.
                    if (mem_done) begin
                        resp_word <= mem_we ? status_word(ST_ACK) : mem_rdata;
                        ser_count <= mem_we ? 3'd1 : 3'd4;
                        ser_load  <= 1'b1;
                        state     <= RESP;
                    end else if (mem_tmr == 10'(MEM_TO - 1)) begin
                        resp_word <= status_word(ST_TIMEOUT);
                        ser_count <= 3'd1;
                        ser_load  <= 1'b1;
                        err_strb  <= 1'b1;
                        state     <= RESP;
                    end else begin
                        mem_tmr <= mem_tmr + 10'd1;
                    end
                end
                RESP: begin
                    if (ser_done) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    resp_serializer u_ser (
        .clk        (clk),
        .reset      (reset),
        .load       (ser_load),
        .load_data  (resp_word),
        .load_count (ser_count),
        .tx_ready   (tx_ready),
        .tx_strb    (tx_strb),
        .tx_data    (tx_data),
        .done       (ser_done)
    );

endmodule

// File: tb/tb_cmd_sequencer.sv
// Directed and randomized frames checked against a frame-level reference model.
module tb_cmd_sequencer;

    localparam int FRAME_TO = 65535;
    localparam int MEM_TO   = 1023;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx_strb;
    logic [7:0]  rx_data;
    logic        tx_ready;
    logic        tx_strb;
    logic [7:0]  tx_data;
    logic        mem_start;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_done;
    logic [31:0] mem_rdata;
    logic        busy;
    logic        err_strb;

    always #5 clk = ~clk;

    cmd_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .rx_strb   (rx_strb),
        .rx_data   (rx_data),
        .tx_ready  (tx_ready),
        .tx_strb   (tx_strb),
        .tx_data   (tx_data),
        .mem_start (mem_start),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_done  (mem_done),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .err_strb  (err_strb)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- observation of DUT outputs ----------------
    logic [7:0]  tx_q[$];
    logic [64:0] mem_q[$];
    int          err_seen  = 0;
    int          proto_bad = 0;
    int          cyc       = 0;
    int          start_cyc = 0;
    int          err_cyc   = 0;
    logic        ready_q   = 1'b0;

    initial forever begin
        @(posedge clk);
        ready_q = tx_ready;
    end

    initial begin
        logic        prev_strb;
        logic        txn_open;
        logic [64:0] txn;
        prev_strb = 1'b0;
        txn_open  = 1'b0;
        txn       = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (tx_strb) begin
                if (!ready_q || prev_strb) proto_bad++;
                tx_q.push_back(tx_data);
            end
            prev_strb = tx_strb;
            if (mem_start) begin
                txn = {mem_we, mem_addr, mem_wdata};
                mem_q.push_back(txn);
                start_cyc = cyc;
                txn_open  = 1'b1;
            end else if (txn_open && ({mem_we, mem_addr, mem_wdata} != txn)) begin
                proto_bad++;
            end
            if (!busy) txn_open = 1'b0;
            if (err_strb) begin
                err_seen++;
                err_cyc = cyc;
            end
        end
    end

    // ---------------- memory responder and tx_ready driver ----------------
    int          mem_lat;
    logic        withhold;
    logic [31:0] rd_val;
    int          force_req;
    int          ready_mode;

    initial begin
        logic pend;
        int   lat_left;
        int   force_ack;
        pend      = 1'b0;
        lat_left  = 0;
        force_ack = 0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            mem_done = 1'b0;
            if (pend) begin
                if (lat_left == 0) begin
                    mem_done  = 1'b1;
                    mem_rdata = rd_val;
                    pend      = 1'b0;
                end else begin
                    lat_left--;
                end
            end
            if (force_req != force_ack) begin
                mem_done  = 1'b1;
                mem_rdata = rd_val;
                force_ack = force_req;
            end
            if (mem_start && !withhold) begin
                pend     = 1'b1;
                lat_left = mem_lat - 1;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        case (ready_mode)
            1:       tx_ready = 1'($urandom_range(0, 1));
            2:       tx_ready = 1'b0;
            default: tx_ready = 1'b1;
        endcase
    end

    // ---------------- reference model ----------------
    logic [7:0]  exp_tx[$];
    logic [64:0] exp_mem[$];
    int          exp_err = 0;
    logic [31:0] addr_m;
    logic [31:0] wdata_m;
    int          tx_obs = 0, tx_exp = 0, mem_obs = 0, mem_exp = 0;

    task automatic push_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) exp_tx.push_back(w[31-8*i -: 8]);
    endtask

    task automatic predict(input logic [7:0] op, input logic [31:0] arg,
                           input logic [31:0] rd, input bit timeout);
        case (op)
            8'h01: begin addr_m = arg;  exp_tx.push_back(8'h00); end
            8'h02: begin wdata_m = arg; exp_tx.push_back(8'h00); end
            8'h03, 8'h04: begin
                exp_mem.push_back({op == 8'h03, addr_m, wdata_m});
                if (timeout) begin
                    exp_tx.push_back(8'hE1);
                    exp_err++;
                end else if (op == 8'h03) begin
                    exp_tx.push_back(8'h00);
                end else begin
                    push_word(rd);
                end
            end
            8'h05: push_word(addr_m);
            default: begin exp_tx.push_back(8'hEE); exp_err++; end
        endcase
    endtask

    task automatic check_all(input string tag);
        int nobs, nexp, mobs, mexp;
        nobs = tx_q.size() - tx_obs;
        nexp = exp_tx.size() - tx_exp;
        chk({tag, "_txcnt"}, 64'(nobs), 64'(nexp));
        for (int i = 0; i < nexp && i < nobs; i++)
            chk({tag, "_txbyte"}, 64'(tx_q[tx_obs+i]), 64'(exp_tx[tx_exp+i]));
        tx_obs = tx_q.size();
        tx_exp = exp_tx.size();
        mobs = mem_q.size() - mem_obs;
        mexp = exp_mem.size() - mem_exp;
        chk({tag, "_memcnt"}, 64'(mobs), 64'(mexp));
        for (int i = 0; i < mexp && i < mobs; i++) begin
            chk({tag, "_mem_we"}, 64'(mem_q[mem_obs+i][64]), 64'(exp_mem[mem_exp+i][64]));
            chk({tag, "_mem_addr_wdata"}, mem_q[mem_obs+i][63:0], exp_mem[mem_exp+i][63:0]);
        end
        mem_obs = mem_q.size();
        mem_exp = exp_mem.size();
        chk({tag, "_errcnt"}, 64'(err_seen), 64'(exp_err));
        chk({tag, "_protocol"}, 64'(proto_bad), 64'd0);
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_strb = 1'b1;
        rx_data = b;
    endtask

    task automatic end_strb();
        @(negedge clk);
        rx_strb = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] op, input logic [31:0] arg);
        send_byte(op);
        for (int i = 0; i < 4; i++) send_byte(arg[31-8*i -: 8]);
        end_strb();
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_idle"}, 64'(busy), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_tx_strb"},   64'(tx_strb),   64'd0);
        chk({tag, "_tx_data"},   64'(tx_data),   64'd0);
        chk({tag, "_mem_start"}, 64'(mem_start), 64'd0);
        chk({tag, "_mem_we"},    64'(mem_we),    64'd0);
        chk({tag, "_mem_addr"},  64'(mem_addr),  64'd0);
        chk({tag, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
        chk({tag, "_busy"},      64'(busy),      64'd0);
        chk({tag, "_err_strb"},  64'(err_strb),  64'd0);
    endtask

    // ---------------- directed then randomized sequence ----------------
    initial begin
        int          n;
        int          sel;
        logic [7:0]  op;
        logic [31:0] arg;

        reset      = 1'b1;
        rx_strb    = 1'b0;
        rx_data    = 8'h00;
        ready_mode = 0;
        withhold   = 1'b0;
        mem_lat    = 4;
        rd_val     = '0;
        force_req  = 0;
        addr_m     = '0;
        wdata_m    = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;
        @(negedge clk);

        // SET_ADDR: busy rises at once, response latency, idle right after the strobe
        predict(8'h01, 32'hAABBCCDD, '0, 0);
        send_frame(8'h01, 32'hAABBCCDD);
        chk("set_busy_rise", 64'(busy), 64'd1);
        n = 1;
        while (!tx_strb && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("set_latency_ge3", 64'(n >= 3 && n < 50), 64'd1);
        @(negedge clk);
        chk("idle_after_last_strb", 64'(busy), 64'd0);
        check_all("set_addr");

        predict(8'h05, '0, '0, 0);
        send_frame(8'h05, 32'h0);
        wait_idle("get_addr", 200);
        check_all("get_addr");

        // WRITE with 4-cycle memory latency
        predict(8'h02, 32'h11223344, '0, 0);
        send_frame(8'h02, 32'h11223344);
        wait_idle("set_wdata", 200);
        predict(8'h01, 32'h00000010, '0, 0);
        send_frame(8'h01, 32'h00000010);
        wait_idle("set_addr10", 200);
        predict(8'h03, '0, '0, 0);
        send_frame(8'h03, 32'h0);
        @(negedge clk);
        chk("wr_start_k2", 64'(mem_start), 64'd1);
        chk("wr_we",       64'(mem_we),    64'd1);
        chk("wr_addr",     64'(mem_addr),  64'h10);
        chk("wr_wdata",    64'(mem_wdata), 64'h11223344);
        @(negedge clk);
        chk("wr_start_one_cycle", 64'(mem_start), 64'd0);
        wait_idle("write", 200);
        check_all("write");

        // READ with tx_ready toggling
        ready_mode = 1;
        rd_val     = 32'hDEADBEEF;
        predict(8'h04, '0, rd_val, 0);
        send_frame(8'h04, 32'h0);
        wait_idle("read", 500);
        check_all("read");
        ready_mode = 0;

        // unknown opcode
        predict(8'h07, '0, '0, 0);
        send_frame(8'h07, 32'h0);
        wait_idle("badop", 200);
        check_all("badop");

        // memory timeout, then a late mem_done
        withhold = 1'b1;
        predict(8'h04, '0, '0, 1);
        send_frame(8'h04, 32'h0);
        wait_idle("mem_to", MEM_TO + 200);
        chk("mem_to_window",
            64'((err_cyc - start_cyc) >= MEM_TO && (err_cyc - start_cyc) <= MEM_TO + 2), 64'd1);
        check_all("mem_to");
        force_req++;
        repeat (10) @(negedge clk);
        chk("late_done_busy", 64'(busy), 64'd0);
        check_all("late_done");

        // partial frame abandoned after FRAME_TO idle cycles
        send_byte(8'h03);
        send_byte(8'h04);
        end_strb();
        repeat (FRAME_TO + 2) @(negedge clk);
        predict(8'h01, 32'h00000020, '0, 0);
        send_frame(8'h01, 32'h00000020);
        wait_idle("frame_to", 200);
        check_all("frame_to");
        predict(8'h05, '0, '0, 0);
        send_frame(8'h05, 32'h0);
        wait_idle("frame_to_addr", 200);
        check_all("frame_to_addr");

        // byte received during WAIT_MEM is dropped
        rd_val = 32'hCAFEF00D;
        predict(8'h04, '0, rd_val, 0);
        send_frame(8'h04, 32'h0);
        repeat (3) @(negedge clk);
        send_byte(8'h55);
        end_strb();
        exp_err++;
        repeat (3) @(negedge clk);
        force_req++;
        wait_idle("drop", 200);
        withhold = 1'b0;
        check_all("drop");
        predict(8'h05, '0, '0, 0);
        send_frame(8'h05, 32'h0);
        wait_idle("drop_after", 200);
        check_all("drop_after");

        // reset while a multi-byte response is in flight
        predict(8'h01, 32'h87654321, '0, 0);
        send_frame(8'h01, 32'h87654321);
        wait_idle("pre_reset", 200);
        send_frame(8'h05, 32'h0);
        n = 0;
        while (!tx_strb && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("rst_first_strb", 64'(tx_strb), 64'd1);
        exp_tx.push_back(8'h87);
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("mid_reset");
        reset   = 1'b0;
        addr_m  = '0;
        wdata_m = '0;
        repeat (20) @(negedge clk);
        check_all("mid_reset");
        predict(8'h05, '0, '0, 0);
        send_frame(8'h05, 32'h0);
        wait_idle("post_reset", 200);
        check_all("post_reset");

        // randomized frames
        ready_mode = 1;
        for (int it = 0; it < 30; it++) begin
            sel = $urandom_range(0, 6);
            if (sel <= 4)      op = 8'(sel + 1);
            else if (sel == 5) op = 8'($urandom_range(6, 255));
            else               op = 8'h03;
            arg     = $urandom;
            rd_val  = $urandom;
            mem_lat = $urandom_range(1, 8);
            predict(op, arg, rd_val, 0);
            send_frame(op, arg);
            wait_idle("rand", 400);
            check_all("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cmd_sequencer.md
# cmd_sequencer

Command sequencer between the byte-oriented serial receiver/transmitter and the HyperRAM controller. It assembles 5-byte frames (opcode + 32-bit big-endian operand) and decodes the opcode. It updates the address/write-data registers, issues single read/write transactions to the memory controller, and returns a response over the transmit byte interface.

## Interface
- FRAME_TO, 65535: idle cycles after which a partial frame is discarded
- MEM_TO, 1023: cycles allowed between mem_start and mem_done

- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- rx_strb  in  1  one-cycle pulse, rx_data valid
- rx_data  in  8  received byte
- tx_ready  in  1  transmitter can accept a byte
- tx_strb  out  1  one-cycle pulse, tx_data valid
- tx_data  out  8  byte to transmit
- mem_start  out  1  one-cycle transaction request
- mem_we  out  1  1 = write, 0 = read; held from mem_start until completion
- mem_addr  out  32  transaction address (mirrors address register)
- mem_wdata  out  32  write data (mirrors write-data register)
- mem_done  in  1  one-cycle completion pulse; mem_rdata valid with it
- mem_rdata  in  32  read data
- busy  out  1  high in any state other than IDLE
- err_strb  out  1  one-cycle pulse on dropped byte, unknown opcode or timeout

## Operation
- States: IDLE (collecting), EXEC, WAIT_MEM, RESP.
- IDLE: each rx_strb shifts rx_data into a 40-bit frame register MSB-first and increments the byte count (0..4). The fifth byte moves the FSM to EXEC, and the count returns to 0.
- Opcodes, each producing one response:
  - 0x01 SET_ADDR: address register ← operand; response 0x00.
  - 0x02 SET_WDATA: write-data register ← operand; response 0x00.
  - 0x03 WRITE: mem_start with mem_we=1; on mem_done, response 0x00.
  - 0x04 READ: mem_start with mem_we=0; on mem_done, capture mem_rdata; response 4 bytes MSB first.
  - 0x05 GET_ADDR: response = address register, 4 bytes MSB first; no memory access.
  - Other: response 0xEE, err_strb.
- WAIT_MEM: mem_done is sampled only in this state. If MEM_TO cycles elapse without it, response 0xE1, err_strb, and the FSM returns via RESP. A late mem_done in IDLE is ignored.
- RESP: sends queued bytes, then returns to IDLE.
- rx_strb while busy: byte dropped, err_strb pulses, frame state untouched.
- Partial frame (count 1..4) with no rx_strb for FRAME_TO consecutive cycles: count returns to 0, no response, no err_strb.

## Timing
- Reset values:
  - Outputs: tx_strb 0, tx_data 0x00, mem_start 0, mem_we 0, mem_addr 0, mem_wdata 0, busy 0, err_strb 0.
  - Internal: address/write-data/read-capture registers 0, byte count 0, state IDLE.
- The fifth rx_strb sampled at edge k → EXEC during cycle k+1 → mem_start high for exactly cycle k+2 (WRITE/READ). busy rises at k+1.
- mem_we is valid from mem_start through completion. mem_addr/mem_wdata are stable from mem_start until the FSM leaves WAIT_MEM.
- mem_done sampled at edge d → RESP from d+1; read data is registered at edge d.
- tx handshake:
  - tx_strb is asserted only in a cycle where tx_ready was sampled high at the previous edge.
  - tx_strb is never high in two consecutive cycles.
  - tx_data is held until the next strobe.
- After the last response byte's tx_strb cycle, the FSM is in IDLE (busy 0) on the next cycle.
- A SET_* frame completes from its fifth byte to response tx_strb in ≥3 cycles when tx_ready is constantly high.
- Counters: frame timeout is 16 bits and saturates (no wrap). Memory timeout is 10 bits. Both clear on every qualifying event.
- reset mid-operation: the FSM returns to IDLE on the next edge, pending response bytes are discarded, and no further mem_start or tx_strb is issued.

## Structure
- Package cmd_seq_pkg holds:
  - opcode constants (0x01–0x05)
  - status bytes (0x00 ack, 0xEE bad opcode, 0xE1 timeout)
  - FSM state enum
  - frame length constant 5
- One sub-module, resp_serializer: loads 1 or 4 bytes plus a count, shifts them out MSB first under the tx_ready/tx_strb handshake, and signals done.

## Test plan
- Frames 01 AABBCCDD, then 05 00000000 → responses 0x00, then AA BB CC DD; mem_start never asserted.
- 02 11223344, 01 00000010, 03 00000000 with mem_done 4 cycles after mem_start → mem_start once with mem_we=1, mem_addr 0x10, mem_wdata 0x11223344; response 0x00.
- 04 00000000 with mem_rdata 0xDEADBEEF on mem_done → mem_we=0, response DE AD BE EF; tx_ready toggled to verify no strobe while low and no back-to-back strobes.
- 07 00000000 → response 0xEE, one err_strb. Then READ with mem_done withheld → after MEM_TO cycles, response 0xE1, err_strb; a late mem_done has no effect.
- Two bytes, then FRAME_TO idle cycles, then a full 01 00000020 frame → only one response (0x00); address register = 0x20.
- rx_strb during WAIT_MEM → err_strb, byte dropped; reset asserted during RESP → outputs at reset values next cycle, remaining bytes not sent.
